spectrum_vga_buffer: RTL and testbench
======================================

SPECTRUM_VGA_BUFFER -- requirements
Module: spectrum_vga_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL provide these parameters:
- MAG_W, default 24, input magnitude width.
- MAG_SHIFT, default 14, right shift applied before saturation.
- DECAY_STEP, default 16, peak-hold decay per frame.
REQ-003 The block SHALL provide these ports:
- clk  in  1  pixel/system clock.
- rst  in  1  asynchronous active-high reset.
- bin_valid_i  in  1  bin write strobe.
- bin_idx_i  in  4  bin index 0..15.
- bin_mag_i  in  MAG_W  unsigned bin magnitude.
- bin_last_i  in  1  qualifies bin_valid_i; marks the frame's final bin.
- display_start_o  out  1  complete frame available for the VGA controller.
- vga_buff_reading_i  in  1  VGA controller is copying the read bank.
- vga_buff_radd_a_i  in  4  read address, port A.
- vga_buff_radd_b_i  in  4  read address, port B.
- vga_buff_rdata_a_o  out  16  read data, port A.
- vga_buff_rdata_b_o  out  16  read data, port B.
- frame_drop_cnt_o  out  8  saturating count of overwritten completed frames.
- bank_sel_o  out  1  index of the current read bank.

Function
REQ-004 The block SHALL use two 16x16 banks (ping-pong): the write bank takes bins and the read bank serves both read ports.
REQ-005 On bin_valid_i, the write bank SHALL store bin_idx_i <- {6'b0, min(bin_mag_i >> MAG_SHIFT, 1023)}.
REQ-006 A frame SHALL be complete on bin_valid_i & bin_last_i, regardless of which indices were written.
REQ-007 Read data SHALL be valid exactly 2 clk cycles after the address is presented, with both stages registered.
REQ-008 Ports A and B SHALL be independent and may read the same address in the same cycle.
REQ-009 The FSM SHALL have states EMPTY, PENDING and READING, plus a flag write_full.
REQ-010 In EMPTY, frame complete SHALL swap the banks and move to PENDING.
REQ-011 In PENDING, display_start_o SHALL be 1; when vga_buff_reading_i is 1, the FSM SHALL go to READING and display_start_o SHALL be 0 from the next cycle.
REQ-012 In READING, when vga_buff_reading_i is 0: if write_full, or a frame completes that same cycle, the block SHALL swap, clear write_full and go to PENDING; otherwise it SHALL go to EMPTY.
REQ-013 In PENDING and READING, frame complete SHALL set write_full and SHALL NOT swap; the read bank is locked.
REQ-014 Frame complete while write_full is already 1 SHALL increment frame_drop_cnt_o, saturating at 255; the newer data overwrites the write bank.
REQ-015 Writes in the cycle of a swap SHALL land in the pre-swap write bank.
REQ-016 bank_sel_o SHALL toggle on every swap.

Reset
REQ-017 While rst=1, the block SHALL hold:
- FSM in EMPTY, write_full=0.
- display_start_o=0, bank_sel_o=0, frame_drop_cnt_o=0.
- rdata pipelines =0, peak registers =0.
REQ-018 Bank contents are undefined after reset, and reads before the first swap return don't-care values.
REQ-019 Reset mid-frame SHALL discard the partial frame; the first complete frame after reset SHALL go to PENDING.

Configuration
REQ-020 With macro SPECTRUM_PEAK_HOLD_EN defined:
- 16 peak registers (10 bit) SHALL be kept.
- The stored value SHALL be max(scaled, peak-DECAY_STEP clamped at 0), and the peak SHALL be updated with the stored value.
- Decay SHALL apply once per write of that index.
REQ-021 Without SPECTRUM_PEAK_HOLD_EN, the block SHALL store the scaled value directly and SHALL contain no peak registers.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then write bins 0..15 with mag=k<<14, last on 15 -> display_start_o=1 the next cycle, bank_sel_o=1, radd=5 returns 5 two cycles later.
- mag=24'hFFFFFF -> data 16'd1023; mag=(3<<14)+16383 -> data 16'd3.
- PENDING, then reading_i rises -> display_start_o falls next cycle; a frame completing during READING -> no swap, and the old data is still read; reading_i falls -> swap, display_start_o=1.
- Three frames completed while READING -> frame_drop_cnt_o=2; 300 drops -> 255.
- rst pulse mid-frame (bin 7) -> all outputs 0; the next full frame -> PENDING.
- With SPECTRUM_PEAK_HOLD_EN, bin 3 values 1000 then 0 -> stored 1000 then 984; without the macro -> 1000 then 0.

Source files
------------

// File: rtl/spectrum_vga_buffer_if.sv
// Bin-write / VGA-read bus for spectrum_vga_buffer. The master side is the
// spectrum producer plus the VGA controller; the slave side is the buffer.
interface spectrum_vga_buffer_if #(
  parameter int unsigned MAG_W = 24
);
  logic             bin_valid_i;
  logic [3:0]       bin_idx_i;
  logic [MAG_W-1:0] bin_mag_i;
  logic             bin_last_i;
  logic             display_start_o;
  logic             vga_buff_reading_i;
  logic [3:0]       vga_buff_radd_a_i;
  logic [3:0]       vga_buff_radd_b_i;
  logic [15:0]      vga_buff_rdata_a_o;
  logic [15:0]      vga_buff_rdata_b_o;
  logic [7:0]       frame_drop_cnt_o;
  logic             bank_sel_o;

  modport master (
    output bin_valid_i, bin_idx_i, bin_mag_i, bin_last_i,
    output vga_buff_reading_i, vga_buff_radd_a_i, vga_buff_radd_b_i,
    input  display_start_o, vga_buff_rdata_a_o, vga_buff_rdata_b_o,
    input  frame_drop_cnt_o, bank_sel_o
  );

  modport slave (
    input  bin_valid_i, bin_idx_i, bin_mag_i, bin_last_i,
    input  vga_buff_reading_i, vga_buff_radd_a_i, vga_buff_radd_b_i,
    output display_start_o, vga_buff_rdata_a_o, vga_buff_rdata_b_o,
    output frame_drop_cnt_o, bank_sel_o
  );
endinterface

// File: rtl/spectrum_vga_buffer.sv
// Ping-pong 16-bin spectrum buffer between an FFT magnitude stream and a VGA
// reader. Define SPECTRUM_PEAK_HOLD_EN to enable per-bin peak hold with decay.
module spectrum_vga_buffer #(
  parameter int unsigned MAG_W      = 24,
  parameter int unsigned MAG_SHIFT  = 14,
  parameter int unsigned DECAY_STEP = 16
) (
  input logic                clk,
  input logic                rst,
  spectrum_vga_buffer_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, PENDING, READING} state_t;

  state_t      state;
  logic        write_full;
  logic        display_start;
  logic        bank_sel;
  logic [7:0]  drop_cnt;
  logic        frame_done;
  logic [MAG_W-1:0] mag_shifted;
  logic [9:0]  scaled;
  logic [9:0]  stored;
  logic [15:0] mem [2][16];
  logic [15:0] rd_a1, rd_b1, rd_a2, rd_b2;

  assign frame_done  = bus.bin_valid_i & bus.bin_last_i;
  assign mag_shifted = bus.bin_mag_i >> MAG_SHIFT;

  always_comb begin
    scaled = mag_shifted[9:0];
    if (mag_shifted > MAG_W'(1023)) scaled = 10'd1023;
  end

`ifdef SPECTRUM_PEAK_HOLD_EN
  logic [9:0] peak [16];
  logic [9:0] decayed;

  always_comb begin
    decayed = '0;
    if (peak[bus.bin_idx_i] >= 10'(DECAY_STEP))
      decayed = peak[bus.bin_idx_i] - 10'(DECAY_STEP);
    stored = (scaled > decayed) ? scaled : decayed;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 16; i++) peak[i] <= '0;
    end else if (bus.bin_valid_i) begin
      peak[bus.bin_idx_i] <= stored;
    end
  end
`else
  assign stored = scaled;
`endif

  // The write bank is always the one not selected for reading; a swap in the
  // same cycle still sees the old bank_sel, so the write lands pre-swap.
  always_ff @(posedge clk) begin
    if (bus.bin_valid_i) mem[~bank_sel][bus.bin_idx_i] <= {6'b0, stored};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_a1 <= '0;
      rd_b1 <= '0;
      rd_a2 <= '0;
      rd_b2 <= '0;
    end else begin
      rd_a1 <= mem[bank_sel][bus.vga_buff_radd_a_i];
      rd_b1 <= mem[bank_sel][bus.vga_buff_radd_b_i];
      rd_a2 <= rd_a1;
      rd_b2 <= rd_b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= EMPTY;
      write_full    <= 1'b0;
      display_start <= 1'b0;
      bank_sel      <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      if (frame_done && write_full && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      case (state)
        EMPTY: begin
          if (frame_done) begin
            bank_sel      <= ~bank_sel;
            display_start <= 1'b1;
            state         <= PENDING;
          end
        end
        PENDING: begin
          if (frame_done) write_full <= 1'b1;
          if (bus.vga_buff_reading_i) begin
            display_start <= 1'b0;
            state         <= READING;
          end
        end
        READING: begin
          if (!bus.vga_buff_reading_i) begin
            if (write_full || frame_done) begin
              bank_sel      <= ~bank_sel;
              write_full    <= 1'b0;
              display_start <= 1'b1;
              state         <= PENDING;
            end else begin
              state <= EMPTY;
            end
          end else if (frame_done) begin
            write_full <= 1'b1;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.display_start_o    = display_start;
  assign bus.bank_sel_o         = bank_sel;
  assign bus.frame_drop_cnt_o   = drop_cnt;
  assign bus.vga_buff_rdata_a_o = rd_a2;
  assign bus.vga_buff_rdata_b_o = rd_b2;

endmodule

// File: tb/tb_spectrum_vga_buffer.sv
// Directed bench for spectrum_vga_buffer: saturation table, ping-pong handshake,
// drop counting, mid-frame reset and (optionally) peak-hold decay.
module tb_spectrum_vga_buffer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spectrum_vga_buffer_if #(.MAG_W(24)) bus ();

  spectrum_vga_buffer #(
    .MAG_W(24),
    .MAG_SHIFT(14),
    .DECAY_STEP(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    logic [3:0]  idx;
    logic [23:0] mag;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [16];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [15:0] da, db;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.bin_valid_i        = 1'b0;
    bus.bin_idx_i          = '0;
    bus.bin_mag_i          = '0;
    bus.bin_last_i         = 1'b0;
    bus.vga_buff_reading_i = 1'b0;
    bus.vga_buff_radd_a_i  = '0;
    bus.vga_buff_radd_b_i  = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    check("rst_display_start", 32'(bus.display_start_o), 0);
    check("rst_bank_sel", 32'(bus.bank_sel_o), 0);
    check("rst_drop_cnt", 32'(bus.frame_drop_cnt_o), 0);
    check("rst_rdata_a", 32'(bus.vga_buff_rdata_a_o), 0);
    check("rst_rdata_b", 32'(bus.vga_buff_rdata_b_o), 0);
    rst = 1'b0;
  endtask

  // Called at a negedge; the bin is captured on the following posedge.
  task automatic write_bin(input logic [3:0] idx, input logic [23:0] mag, input logic last);
    bus.bin_valid_i = 1'b1;
    bus.bin_idx_i   = idx;
    bus.bin_mag_i   = mag;
    bus.bin_last_i  = last;
    @(negedge clk);
    bus.bin_valid_i = 1'b0;
    bus.bin_last_i  = 1'b0;
  endtask

  task automatic read2(input logic [3:0] a, input logic [3:0] b,
                       output logic [15:0] ra, output logic [15:0] rb);
    bus.vga_buff_radd_a_i = a;
    bus.vga_buff_radd_b_i = b;
    @(negedge clk);
    @(negedge clk);
    ra = bus.vga_buff_rdata_a_o;
    rb = bus.vga_buff_rdata_b_o;
  endtask

  task automatic set_reading(input logic r);
    bus.vga_buff_reading_i = r;
    @(negedge clk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{4'd0,  24'd0,                   16'd0};
    vecs[1]  = '{4'd1,  24'd16383,               16'd0};
    vecs[2]  = '{4'd2,  24'd16384,               16'd1};
    vecs[3]  = '{4'd3,  (24'd3 << 14) + 24'd16383, 16'd3};
    vecs[4]  = '{4'd4,  24'hFFFFFF,              16'd1023};
    vecs[5]  = '{4'd5,  24'hFFC000,              16'd1023};
    vecs[6]  = '{4'd6,  (24'd1022 << 14) + 24'd16383, 16'd1022};
    vecs[7]  = '{4'd7,  24'd500 << 14,           16'd500};
    vecs[8]  = '{4'd8,  24'h800000,              16'd512};
    vecs[9]  = '{4'd9,  24'h7FFFFF,              16'd511};
    vecs[10] = '{4'd10, 24'd100 << 14,           16'd100};
    vecs[11] = '{4'd11, 24'd7 << 14,             16'd7};
    vecs[12] = '{4'd12, 24'h123456,              16'd72};
    vecs[13] = '{4'd13, 24'hABCDEF,              16'd687};
    vecs[14] = '{4'd14, 24'h804000,              16'd513};
    vecs[15] = '{4'd15, 24'd15 << 14,            16'd15};

    clear_inputs();

    // First frame after reset: bins k<<14, last on 15
    do_reset();
    for (int k = 0; k < 16; k++) write_bin(4'(k), 24'(k) << 14, k == 15);
    check("s1_display_start", 32'(bus.display_start_o), 1);
    check("s1_bank_sel", 32'(bus.bank_sel_o), 1);
    read2(4'd0, 4'd15, da, db);
    check("s1_read_a0", 32'(da), 0);
    check("s1_read_b15", 32'(db), 15);
    bus.vga_buff_radd_a_i = 4'd5;
    bus.vga_buff_radd_b_i = 4'd5;
    @(negedge clk);
    check("s1_latency_a_1cyc", 32'(bus.vga_buff_rdata_a_o), 0);
    check("s1_latency_b_1cyc", 32'(bus.vga_buff_rdata_b_o), 15);
    @(negedge clk);
    check("s1_read_a5", 32'(bus.vga_buff_rdata_a_o), 5);
    check("s1_read_b5_same_addr", 32'(bus.vga_buff_rdata_b_o), 5);

    // PENDING -> READING, table frame written while read bank is locked
    set_reading(1'b1);
    check("s3_display_fall", 32'(bus.display_start_o), 0);
    for (int i = 0; i < 16; i++) write_bin(vecs[i].idx, vecs[i].mag, i == 15);
    check("s3_no_swap_bank_sel", 32'(bus.bank_sel_o), 1);
    check("s3_no_swap_display", 32'(bus.display_start_o), 0);
    read2(4'd5, 4'd4, da, db);
    check("s3_old_data_a5", 32'(da), 5);
    check("s3_old_data_b4", 32'(db), 4);
    set_reading(1'b0);
    check("s3_swap_bank_sel", 32'(bus.bank_sel_o), 0);
    check("s3_swap_display", 32'(bus.display_start_o), 1);
    for (int i = 0; i < 16; i++) begin
      read2(vecs[i].idx, vecs[15 - i].idx, da, db);
      check($sformatf("tbl_a_%0d", i), 32'(da), 32'(vecs[i].exp));
      check($sformatf("tbl_b_%0d", 15 - i), 32'(db), 32'(vecs[15 - i].exp));
    end

    // Drop counting while the reader holds the read bank
    do_reset();
    write_bin(4'd0, 24'd1 << 14, 1'b1);
    check("s4_pending", 32'(bus.display_start_o), 1);
    set_reading(1'b1);
    for (int f = 0; f < 3; f++) write_bin(4'd0, 24'd2 << 14, 1'b1);
    check("s4_drop_2", 32'(bus.frame_drop_cnt_o), 2);
    check("s4_bank_locked", 32'(bus.bank_sel_o), 1);
    for (int f = 0; f < 253; f++) write_bin(4'd1, 24'd3 << 14, 1'b1);
    check("s4_drop_255", 32'(bus.frame_drop_cnt_o), 255);
    for (int f = 0; f < 45; f++) write_bin(4'd1, 24'd3 << 14, 1'b1);
    check("s4_drop_sat_300", 32'(bus.frame_drop_cnt_o), 255);
    set_reading(1'b0);
    check("s4_release_swap", 32'(bus.bank_sel_o), 0);
    check("s4_release_display", 32'(bus.display_start_o), 1);

    // Reset in the middle of a frame (after bin 7)
    for (int k = 0; k < 8; k++) write_bin(4'(k), 24'(k + 40) << 14, 1'b0);
    do_reset();
    for (int k = 0; k < 16; k++) write_bin(4'(k), 24'(k + 20) << 14, k == 15);
    check("s5_display_start", 32'(bus.display_start_o), 1);
    check("s5_bank_sel", 32'(bus.bank_sel_o), 1);
    read2(4'd7, 4'd0, da, db);
    check("s5_read_a7", 32'(da), 27);
    check("s5_read_b0", 32'(db), 20);

    // Peak hold: bin 3 gets 1000 then 0
    do_reset();
    write_bin(4'd3, 24'd1000 << 14, 1'b1);
    read2(4'd3, 4'd3, da, db);
    check("s6_first_1000", 32'(da), 1000);
    set_reading(1'b1);
    set_reading(1'b0);
    check("s6_empty_no_display", 32'(bus.display_start_o), 0);
    check("s6_empty_bank_sel", 32'(bus.bank_sel_o), 1);
    write_bin(4'd3, 24'd0, 1'b1);
    check("s6_second_swap", 32'(bus.bank_sel_o), 0);
    read2(4'd3, 4'd3, da, db);
`ifdef SPECTRUM_PEAK_HOLD_EN
    check("s6_second_decayed", 32'(da), 984);
`else
    check("s6_second_direct", 32'(da), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
